lsq_param: RTL and testbench
============================

// Module: lsq_param
// PURPOSE
//  Parametrised load/store queue: circular buffer of in-flight memory ops in program order. Takes dispatch, AGU addresses and
//  store-data wakeups; forwards store->load; issues misses and retired stores to memory over a valid/ready port, one outstanding.
//  Sits between dispatch/AGUs/ROB and data memory; returns load results on the CDB.
// PARAMETERS
//  DEPTH   16  entries, power of 2 >= 4; ptr width PW=$clog2(DEPTH), count width PW+1
//  N_AGU   3   AGU address ports
//  N_WAKE  3   CDB wakeup ports
//  ROB_W   6   ROB index width;  TAG_W  6  physical tag width
// PORTS
//  clk            in   1            clock, rising edge
//  rst_n          in   1            async active-low reset
//  disp_valid     in   1            enqueue request
//  disp_ready     out  1            ~full (count<DEPTH)
//  disp_is_load   in   1            1=load 0=store
//  disp_byte      in   1            1=LB/SB 0=LW/SW
//  disp_rob       in   ROB_W        ROB index
//  disp_tag       in   TAG_W        load rd tag / store rs2 tag
//  disp_data_rdy  in   1            store rs2 already available
//  disp_data      in   32           store rs2 value
//  agu_valid      in   N_AGU        per-port address valid
//  agu_rob        in   N_AGU*ROB_W  ROB index per port
//  agu_addr       in   N_AGU*32     effective address per port
//  wk_valid       in   N_WAKE       wakeup valid
//  wk_tag         in   N_WAKE*TAG_W wakeup tag
//  wk_data        in   N_WAKE*32    wakeup value
//  ret_valid      in   2            ROB retire strobes
//  ret_rob        in   2*ROB_W      retired ROB indices
//  mem_req_valid  out  1            memory request
//  mem_req_ready  in   1            memory accepts
//  mem_req_we     out  1            1=store
//  mem_req_byte   out  1            byte access
//  mem_req_addr   out  32           address
//  mem_req_wdata  out  32           store data (byte in [7:0])
//  mem_resp_valid in   1            response (loads and store acks)
//  mem_resp_rdata in   32           load data, already byte-selected
//  ld_valid       out  1            load result broadcast
//  ld_tag         out  TAG_W        rd tag
//  ld_rob         out  ROB_W        ROB index (ROB marks complete)
//  ld_data        out  32           result; LB sign-extended from [7]
//  count          out  PW+1         occupied entries
// BEHAVIOUR
//  - Reset: head=tail=count=0, all entries invalid, FSM IDLE, every output 0 except disp_ready=1.
//  - Entry: valid,is_load,byte,addr_vld,addr,rob,tag,data_rdy,data,done,retired. Enqueue at tail when disp_valid&disp_ready; tail wraps DEPTH-1->0.
//  - disp_valid while full: ignored, no state change. Enqueue and dequeue in the same cycle: count unchanged.
//  - AGU: each agu_valid writes addr, sets addr_vld on the valid entry with matching rob; no match -> dropped.
//  - Wakeup: valid store with ~data_rdy and tag==wk_tag[k] latches data next edge; lowest k wins; same-cycle dispatch also snooped.
//  - Retire: entry with rob==ret_rob[k] & ret_valid[k] sets retired; both ports may hit in one cycle.
//  - Load select (comb, oldest first): valid, is_load, addr_vld, ~done, every older store addr_vld.
//    Youngest older store on same addr[31:2]: same addr & size & data_rdy -> forward; same addr & size & ~data_rdy -> wait;
//    else (partial overlap) wait for store to drain. No match -> memory miss.
//  - Forward: ld_* asserted 1 cycle after select, done set. Suppressed the cycle mem_resp_valid returns a load; retried next cycle.
//  - FSM IDLE->REQ->WAIT->IDLE. IDLE: head retired store with data_rdy has priority, else selected miss load; latch into mem_req_*.
//    REQ: hold mem_req_valid and all mem_req_* stable until mem_req_ready. WAIT: on mem_resp_valid -> IDLE;
//    load: ld_* next cycle with ld_data=resp (LB sign-extended), done=1; store: entry freed.
//  - Dequeue (max 1/cycle): head valid and (load: done&retired; store: write acked). Head advances, wraps.
//  - Byte stores: mem_req_wdata={24'b0,data[7:0]}.
//  - ld_valid is a 1-cycle pulse, max 1/cycle; all outputs registered except disp_ready and count.
//  - rst_n low mid-transaction: immediate clear, FSM IDLE, outstanding response discarded.
// TESTING
//  1 Reset 1, SW rob=1 data 0xDEADBEEF, AGU 0x100, LW rob=2 tag=9, AGU 0x100 -> ld_valid tag=9 data=0xDEADBEEF; no mem_req.
//  2 LW rob=3 addr 0x40, empty queue, mem returns 0x12345678 -> mem_req we=0 addr=0x40; ld_data=0x12345678.
//  3 SB 0x80 data_rdy=0, LB 0x80 -> load waits; wakeup tag match val 0x000000F0 -> ld_data=0xFFFFFFF0.
//  4 Fill 16 entries -> disp_ready=0, 17th dropped; retire+drain head -> disp_ready=1; tail wrap 15->0 verified.
//  5 SW 0x200 retired, mem_req_ready low 3 cycles -> mem_req_* stable; ack frees entry, count-1.
//  6 rst_n low while in WAIT -> all outputs to reset values same cycle; late mem_resp ignored.

Source files
------------

// File: rtl/lsq_param_if.sv
// Signal bundle for the load/store queue: dispatch, AGU, wakeup, retire, memory port, load result.
// master is the core/memory side, slave is the queue itself.
interface lsq_param_if #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned N_AGU  = 3,
   parameter int unsigned N_WAKE = 3,
   parameter int unsigned ROB_W  = 6,
   parameter int unsigned TAG_W  = 6
);
   localparam int unsigned PW = $clog2(DEPTH);

   logic                      disp_valid;
   logic                      disp_ready;
   logic                      disp_is_load;
   logic                      disp_byte;
   logic [ROB_W-1:0]          disp_rob;
   logic [TAG_W-1:0]          disp_tag;
   logic                      disp_data_rdy;
   logic [31:0]               disp_data;
   logic [N_AGU-1:0]          agu_valid;
   logic [N_AGU*ROB_W-1:0]    agu_rob;
   logic [N_AGU*32-1:0]       agu_addr;
   logic [N_WAKE-1:0]         wk_valid;
   logic [N_WAKE*TAG_W-1:0]   wk_tag;
   logic [N_WAKE*32-1:0]      wk_data;
   logic [1:0]                ret_valid;
   logic [2*ROB_W-1:0]        ret_rob;
   logic                      mem_req_valid;
   logic                      mem_req_ready;
   logic                      mem_req_we;
   logic                      mem_req_byte;
   logic [31:0]               mem_req_addr;
   logic [31:0]               mem_req_wdata;
   logic                      mem_resp_valid;
   logic [31:0]               mem_resp_rdata;
   logic                      ld_valid;
   logic [TAG_W-1:0]          ld_tag;
   logic [ROB_W-1:0]          ld_rob;
   logic [31:0]               ld_data;
   logic [PW:0]               count;

   modport master (
      output disp_valid, disp_is_load, disp_byte, disp_rob, disp_tag, disp_data_rdy, disp_data,
      output agu_valid, agu_rob, agu_addr, wk_valid, wk_tag, wk_data, ret_valid, ret_rob,
      output mem_req_ready, mem_resp_valid, mem_resp_rdata,
      input  disp_ready, mem_req_valid, mem_req_we, mem_req_byte, mem_req_addr, mem_req_wdata,
      input  ld_valid, ld_tag, ld_rob, ld_data, count
   );

   modport slave (
      input  disp_valid, disp_is_load, disp_byte, disp_rob, disp_tag, disp_data_rdy, disp_data,
      input  agu_valid, agu_rob, agu_addr, wk_valid, wk_tag, wk_data, ret_valid, ret_rob,
      input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
      output disp_ready, mem_req_valid, mem_req_we, mem_req_byte, mem_req_addr, mem_req_wdata,
      output ld_valid, ld_tag, ld_rob, ld_data, count
   );
endinterface

// File: rtl/lsq_param.sv
// Load/store queue: program-ordered circular buffer with store->load forwarding and a
// single-outstanding memory port for missing loads and retired stores.
module lsq_param #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned N_AGU  = 3,
   parameter int unsigned N_WAKE = 3,
   parameter int unsigned ROB_W  = 6,
   parameter int unsigned TAG_W  = 6
) (
   input logic        clk,
   input logic        rst_n,
   lsq_param_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

   typedef struct packed {
      logic             valid;
      logic             is_load;
      logic             is_byte;
      logic             addr_vld;
      logic [31:0]      addr;
      logic [ROB_W-1:0] rob;
      logic [TAG_W-1:0] tag;
      logic             data_rdy;
      logic [31:0]      data;
      logic             done;
      logic             retired;
      logic             issued;
   } entry_t;

   entry_t [DEPTH-1:0] ent_q, ent_d;
   logic [PW-1:0]      head_q, tail_q, cur_q;
   logic [PW:0]        count_q;
   state_e             state_q, state_d;
   logic               cur_load_q;

   logic               req_valid_q, req_we_q, req_byte_q;
   logic [31:0]        req_addr_q, req_wdata_q;
   logic               ld_valid_q;
   logic [TAG_W-1:0]   ld_tag_q;
   logic [ROB_W-1:0]   ld_rob_q;
   logic [31:0]        ld_data_q;

   logic               enq, deq, store_go, miss_go, resp_fire, resp_load, fwd_fire;
   logic               fwd_found, miss_found, snoop_hit;
   logic [PW-1:0]      fwd_idx, miss_idx;
   logic [31:0]        fwd_data, snoop_data;
   entry_t             head_ent;

   assign head_ent  = ent_q[head_q];
   assign enq       = bus.disp_valid && (count_q < FULL);
   assign deq       = head_ent.valid && head_ent.done && (head_ent.retired || !head_ent.is_load);
   assign store_go  = (state_q == StIdle) && head_ent.valid && !head_ent.is_load &&
                      head_ent.addr_vld && head_ent.data_rdy && head_ent.retired && !head_ent.done;
   assign miss_go   = (state_q == StIdle) && !store_go && miss_found;
   assign resp_fire = (state_q == StWait) && bus.mem_resp_valid;
   assign resp_load = resp_fire && cur_load_q;
   // A memory load result owns the CDB this cycle; the forward retries next cycle.
   assign fwd_fire  = fwd_found && !resp_load;

   // Oldest-first load selection; the last matching older store seen is the youngest one.
   always_comb begin
      logic [PW-1:0] li, oj;
      logic          older_ok, hit, exact, st_rdy;
      logic [31:0]   st_data;
      li = '0; oj = '0; older_ok = 1'b0; hit = 1'b0; exact = 1'b0; st_rdy = 1'b0;
      st_data = '0;
      fwd_found = 1'b0; fwd_idx = '0; fwd_data = '0; miss_found = 1'b0; miss_idx = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         li = head_q + PW'(i);
         older_ok = 1'b1; hit = 1'b0; exact = 1'b0; st_rdy = 1'b0; st_data = '0;
         for (int unsigned j = 0; j < i; j++) begin
            oj = head_q + PW'(j);
            if (ent_q[oj].valid && !ent_q[oj].is_load) begin
               if (!ent_q[oj].addr_vld) begin
                  older_ok = 1'b0;
               end else if (ent_q[oj].addr[31:2] == ent_q[li].addr[31:2]) begin
                  hit     = 1'b1;
                  exact   = (ent_q[oj].addr == ent_q[li].addr) &&
                            (ent_q[oj].is_byte == ent_q[li].is_byte);
                  st_rdy  = ent_q[oj].data_rdy;
                  st_data = ent_q[oj].data;
               end
            end
         end
         if (ent_q[li].valid && ent_q[li].is_load && ent_q[li].addr_vld && !ent_q[li].done &&
             !ent_q[li].issued && older_ok) begin
            if (!hit) begin
               if (!miss_found) begin
                  miss_found = 1'b1;
                  miss_idx   = li;
               end
            end else if (exact && st_rdy && !fwd_found) begin
               fwd_found = 1'b1;
               fwd_idx   = li;
               fwd_data  = ent_q[li].is_byte ? {{24{st_data[7]}}, st_data[7:0]} : st_data;
            end
         end
      end
   end

   always_comb begin
      snoop_hit  = 1'b0;
      snoop_data = '0;
      for (int k = int'(N_WAKE) - 1; k >= 0; k--) begin
         if (bus.wk_valid[k] && bus.wk_tag[k*TAG_W +: TAG_W] == bus.disp_tag) begin
            snoop_hit  = 1'b1;
            snoop_data = bus.wk_data[k*32 +: 32];
         end
      end
   end

   always_comb begin
      ent_d = ent_q;
      for (int unsigned e = 0; e < DEPTH; e++) begin
         for (int unsigned k = 0; k < N_AGU; k++) begin
            if (bus.agu_valid[k] && ent_q[e].valid &&
                ent_q[e].rob == bus.agu_rob[k*ROB_W +: ROB_W]) begin
               ent_d[e].addr_vld = 1'b1;
               ent_d[e].addr     = bus.agu_addr[k*32 +: 32];
            end
         end
         if (ent_q[e].valid && !ent_q[e].is_load && !ent_q[e].data_rdy) begin
            for (int k = int'(N_WAKE) - 1; k >= 0; k--) begin
               if (bus.wk_valid[k] && ent_q[e].tag == bus.wk_tag[k*TAG_W +: TAG_W]) begin
                  ent_d[e].data_rdy = 1'b1;
                  ent_d[e].data     = bus.wk_data[k*32 +: 32];
               end
            end
         end
         for (int unsigned k = 0; k < 2; k++) begin
            if (bus.ret_valid[k] && ent_q[e].valid &&
                ent_q[e].rob == bus.ret_rob[k*ROB_W +: ROB_W]) begin
               ent_d[e].retired = 1'b1;
            end
         end
      end
      if (fwd_fire)  ent_d[fwd_idx].done  = 1'b1;
      if (miss_go)   ent_d[miss_idx].issued = 1'b1;
      if (resp_fire) ent_d[cur_q].done    = 1'b1;
      if (deq)       ent_d[head_q]        = '0;
      if (enq) begin
         ent_d[tail_q]          = '0;
         ent_d[tail_q].valid    = 1'b1;
         ent_d[tail_q].is_load  = bus.disp_is_load;
         ent_d[tail_q].is_byte  = bus.disp_byte;
         ent_d[tail_q].rob      = bus.disp_rob;
         ent_d[tail_q].tag      = bus.disp_tag;
         ent_d[tail_q].data_rdy = !bus.disp_is_load && (bus.disp_data_rdy || snoop_hit);
         ent_d[tail_q].data     = bus.disp_data_rdy ? bus.disp_data : snoop_data;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (store_go || miss_go) state_d = StReq;
         StReq:   if (bus.mem_req_ready)   state_d = StWait;
         StWait:  if (bus.mem_resp_valid)  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         ent_q   <= ent_d;
         if (enq) tail_q <= tail_q + 1'b1;
         if (deq) head_q <= head_q + 1'b1;
         count_q <= count_q + (PW+1)'(enq) - (PW+1)'(deq);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cur_q       <= '0;
         cur_load_q  <= 1'b0;
         req_valid_q <= 1'b0;
         req_we_q    <= 1'b0;
         req_byte_q  <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         req_valid_q <= (state_d == StReq);
         if (store_go) begin
            cur_q       <= head_q;
            cur_load_q  <= 1'b0;
            req_we_q    <= 1'b1;
            req_byte_q  <= head_ent.is_byte;
            req_addr_q  <= head_ent.addr;
            req_wdata_q <= head_ent.is_byte ? {24'b0, head_ent.data[7:0]} : head_ent.data;
         end else if (miss_go) begin
            cur_q       <= miss_idx;
            cur_load_q  <= 1'b1;
            req_we_q    <= 1'b0;
            req_byte_q  <= ent_q[miss_idx].is_byte;
            req_addr_q  <= ent_q[miss_idx].addr;
            req_wdata_q <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_valid_q <= 1'b0;
         ld_tag_q   <= '0;
         ld_rob_q   <= '0;
         ld_data_q  <= '0;
      end else begin
         ld_valid_q <= resp_load || fwd_fire;
         if (resp_load) begin
            ld_tag_q  <= ent_q[cur_q].tag;
            ld_rob_q  <= ent_q[cur_q].rob;
            ld_data_q <= ent_q[cur_q].is_byte ?
                         {{24{bus.mem_resp_rdata[7]}}, bus.mem_resp_rdata[7:0]} :
                         bus.mem_resp_rdata;
         end else if (fwd_found) begin
            ld_tag_q  <= ent_q[fwd_idx].tag;
            ld_rob_q  <= ent_q[fwd_idx].rob;
            ld_data_q <= fwd_data;
         end
      end
   end

   assign bus.disp_ready    = (count_q < FULL);
   assign bus.count         = count_q;
   assign bus.mem_req_valid = req_valid_q;
   assign bus.mem_req_we    = req_we_q;
   assign bus.mem_req_byte  = req_byte_q;
   assign bus.mem_req_addr  = req_addr_q;
   assign bus.mem_req_wdata = req_wdata_q;
   assign bus.ld_valid      = ld_valid_q;
   assign bus.ld_tag        = ld_tag_q;
   assign bus.ld_rob        = ld_rob_q;
   assign bus.ld_data       = ld_data_q;
endmodule

// File: tb/tb_lsq_param.sv
// Directed bench for lsq_param: load results are scoreboarded through an expectation queue,
// memory requests are checked by an in-line responder.
module tb_lsq_param;
   localparam int unsigned DEPTH = 16;

   typedef struct {
      logic [5:0]  tag;
      logic [5:0]  rob;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   ld_seen = 0;
   int   req_cycles = 0;
   exp_t exp_q[$];

   lsq_param_if #(.DEPTH(DEPTH), .N_AGU(3), .N_WAKE(3), .ROB_W(6), .TAG_W(6)) bus ();

   lsq_param #(.DEPTH(DEPTH), .N_AGU(3), .N_WAKE(3), .ROB_W(6), .TAG_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.mem_req_valid) req_cycles++;
      if (rst_n && bus.ld_valid) begin
         ld_seen++;
         if (exp_q.size() == 0) begin
            check("ld_unexpected", 32'(bus.ld_valid), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("ld_tag", 32'(bus.ld_tag), 32'(e.tag));
            check("ld_rob", 32'(bus.ld_rob), 32'(e.rob));
            check("ld_data", bus.ld_data, e.data);
         end
      end
   end

   task automatic dispatch(input logic ld, input logic byt, input logic [5:0] rob,
                           input logic [5:0] tag, input logic rdy, input logic [31:0] data);
      bus.disp_valid = 1'b1; bus.disp_is_load = ld; bus.disp_byte = byt;
      bus.disp_rob = rob; bus.disp_tag = tag; bus.disp_data_rdy = rdy; bus.disp_data = data;
      tick();
      bus.disp_valid = 1'b0;
   endtask

   task automatic agu(input int port, input logic [5:0] rob, input logic [31:0] addr);
      bus.agu_valid = '0;
      bus.agu_valid[port] = 1'b1;
      bus.agu_rob[port*6 +: 6] = rob;
      bus.agu_addr[port*32 +: 32] = addr;
      tick();
      bus.agu_valid = '0;
   endtask

   task automatic retire(input logic [1:0] v, input logic [5:0] r0, input logic [5:0] r1);
      bus.ret_valid = v; bus.ret_rob = {r1, r0};
      tick();
      bus.ret_valid = '0;
   endtask

   task automatic expect_ld(input logic [5:0] tag, input logic [5:0] rob, input logic [31:0] d);
      exp_t e;
      e.tag = tag; e.rob = rob; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic wait_ld();
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
      check("ld_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic serve_mem(input string nm, input logic we, input logic byt,
                            input logic [31:0] addr, input logic [31:0] wd, input int stall,
                            input logic [31:0] rdata);
      int n = 0;
      while (!bus.mem_req_valid && n < 50) begin tick(); n++; end
      check({nm, "_valid"}, 32'(bus.mem_req_valid), 32'd1);
      if (!bus.mem_req_valid) return;
      for (int s = 0; s <= stall; s++) begin
         if (s > 0) check({nm, "_hold"}, 32'(bus.mem_req_valid), 32'd1);
         check({nm, "_we"}, 32'(bus.mem_req_we), 32'(we));
         check({nm, "_byte"}, 32'(bus.mem_req_byte), 32'(byt));
         check({nm, "_addr"}, bus.mem_req_addr, addr);
         if (we) check({nm, "_wdata"}, bus.mem_req_wdata, wd);
         if (s < stall) tick();
      end
      bus.mem_req_ready = 1'b1;
      tick();
      bus.mem_req_ready = 1'b0;
      check({nm, "_dropped"}, 32'(bus.mem_req_valid), 32'd0);
      bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = rdata;
      tick();
      bus.mem_resp_valid = 1'b0;
   endtask

   initial begin
      int seen0, req0, n;
      bus.disp_valid = 1'b0; bus.disp_is_load = 1'b0; bus.disp_byte = 1'b0;
      bus.disp_rob = '0; bus.disp_tag = '0; bus.disp_data_rdy = 1'b0; bus.disp_data = '0;
      bus.agu_valid = '0; bus.agu_rob = '0; bus.agu_addr = '0;
      bus.wk_valid = '0; bus.wk_tag = '0; bus.wk_data = '0;
      bus.ret_valid = '0; bus.ret_rob = '0;
      bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0;
      repeat (3) tick();
      check("rst_disp_ready", 32'(bus.disp_ready), 32'd1);
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_ld_valid", 32'(bus.ld_valid), 32'd0);
      check("rst_mem_req", 32'(bus.mem_req_valid), 32'd0);
      rst_n = 1'b1;
      tick();

      // Word store forwarded to a younger word load, no memory traffic
      req0 = req_cycles;
      dispatch(1'b0, 1'b0, 6'd1, 6'd1, 1'b1, 32'hDEAD_BEEF);
      agu(0, 6'd1, 32'h100);
      expect_ld(6'd9, 6'd2, 32'hDEAD_BEEF);
      dispatch(1'b1, 1'b0, 6'd2, 6'd9, 1'b0, 32'h0);
      agu(2, 6'd2, 32'h100);
      wait_ld();
      check("fwd_no_mem_req", 32'(req_cycles - req0), 32'd0);
      retire(2'b11, 6'd1, 6'd2);
      serve_mem("t1_st", 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 0, 32'h0);
      repeat (3) tick();
      check("t1_count", 32'(bus.count), 32'd0);

      // Load miss to memory
      expect_ld(6'd3, 6'd3, 32'h1234_5678);
      dispatch(1'b1, 1'b0, 6'd3, 6'd3, 1'b0, 32'h0);
      agu(1, 6'd3, 32'h40);
      serve_mem("t2_ld", 1'b0, 1'b0, 32'h40, 32'h0, 0, 32'h1234_5678);
      wait_ld();
      retire(2'b01, 6'd3, 6'd0);
      repeat (2) tick();
      check("t2_count", 32'(bus.count), 32'd0);

      // Byte load waits on a byte store's data, then forwards with sign extension
      req0 = req_cycles; seen0 = ld_seen;
      dispatch(1'b0, 1'b1, 6'd4, 6'd20, 1'b0, 32'h0);
      agu(0, 6'd4, 32'h80);
      dispatch(1'b1, 1'b1, 6'd5, 6'd21, 1'b0, 32'h0);
      agu(0, 6'd5, 32'h80);
      repeat (5) tick();
      check("t3_wait_no_ld", 32'(ld_seen - seen0), 32'd0);
      check("t3_wait_no_req", 32'(req_cycles - req0), 32'd0);
      expect_ld(6'd21, 6'd5, 32'hFFFF_FFF0);
      bus.wk_valid = 3'b110;
      bus.wk_tag = {6'd20, 6'd20, 6'd7};
      bus.wk_data = {32'h0000_007F, 32'h0000_00F0, 32'h0};
      tick();
      bus.wk_valid = '0;
      wait_ld();
      retire(2'b11, 6'd4, 6'd5);
      serve_mem("t3_sb", 1'b1, 1'b1, 32'h80, 32'h0000_00F0, 0, 32'h0);
      repeat (3) tick();
      check("t3_count", 32'(bus.count), 32'd0);

      // Fill to full, drop the extra dispatch, then drain through the wrap point
      for (int i = 0; i < 16; i++) dispatch(1'b1, 1'b0, 6'(16 + i), 6'(i), 1'b0, 32'h0);
      check("t4_full_count", 32'(bus.count), 32'd16);
      check("t4_full_ready", 32'(bus.disp_ready), 32'd0);
      dispatch(1'b1, 1'b0, 6'd40, 6'd40, 1'b0, 32'h0);
      check("t4_drop_count", 32'(bus.count), 32'd16);
      for (int i = 0; i < 16; i++) begin
         agu(i % 3, 6'(16 + i), 32'h400 + 32'(4 * i));
         expect_ld(6'(i), 6'(16 + i), 32'hA000_0000 + 32'(i));
         serve_mem("t4_ld", 1'b0, 1'b0, 32'h400 + 32'(4 * i), 32'h0, 0,
                   32'hA000_0000 + 32'(i));
         wait_ld();
         retire(2'b10, 6'd0, 6'(16 + i));
         tick();
         if (i == 0) begin
            check("t4_drain_count", 32'(bus.count), 32'd15);
            check("t4_drain_ready", 32'(bus.disp_ready), 32'd1);
         end
      end
      check("t4_empty", 32'(bus.count), 32'd0);

      // Retired word store stalled by mem_req_ready
      dispatch(1'b0, 1'b0, 6'd50, 6'd50, 1'b1, 32'hCAFE_F00D);
      agu(1, 6'd50, 32'h200);
      retire(2'b01, 6'd50, 6'd0);
      check("t5_count_before", 32'(bus.count), 32'd1);
      serve_mem("t5_st", 1'b1, 1'b0, 32'h200, 32'hCAFE_F00D, 3, 32'h0);
      check("t5_count_ack", 32'(bus.count), 32'd1);
      tick();
      check("t5_count_after", 32'(bus.count), 32'd0);

      // Reset while a load is outstanding; the late response must be ignored
      dispatch(1'b1, 1'b0, 6'd60, 6'd61, 1'b0, 32'h0);
      agu(0, 6'd60, 32'h600);
      n = 0;
      while (!bus.mem_req_valid && n < 50) begin tick(); n++; end
      check("t6_req", 32'(bus.mem_req_valid), 32'd1);
      bus.mem_req_ready = 1'b1;
      tick();
      bus.mem_req_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("t6_rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
      check("t6_rst_req_addr", bus.mem_req_addr, 32'd0);
      check("t6_rst_ld_valid", 32'(bus.ld_valid), 32'd0);
      check("t6_rst_count", 32'(bus.count), 32'd0);
      check("t6_rst_ready", 32'(bus.disp_ready), 32'd1);
      tick();
      rst_n = 1'b1;
      seen0 = ld_seen; req0 = req_cycles;
      bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'h5555_5555;
      tick();
      bus.mem_resp_valid = 1'b0;
      repeat (5) tick();
      check("t6_late_resp_ld", 32'(ld_seen - seen0), 32'd0);
      check("t6_late_resp_req", 32'(req_cycles - req0), 32'd0);
      check("t6_count", 32'(bus.count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
